sprite_blitter: RTL
===================

# sprite_blitter

- Sequential writer that copies one sprite frame from a sprite-sheet ROM into the 234x176 viewport frame buffer.
- Sits between the game-logic FSM, which issues a blit request per sprite per frame, and the frame-buffer RAM that the scan-out index path later reads.
- Applies horizontal mirroring, colour-key transparency and viewport clipping, producing one pixel per clock through a fixed-latency ROM pipeline.

## Interface
Parameters:
- VIEW_W, 234: viewport width in pixels
- VIEW_H, 176: viewport height in pixels
- ROM_AW, 18: sprite ROM address width
- FB_AW, 16: frame-buffer address width
- PIX_W, 4: palette index width
- ROM_LAT, 2: sprite ROM read latency in cycles, 1..4

Ports:
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  blit request; sampled only in IDLE
- pos_x  in  8  sprite horizontal centre, viewport-relative
- pos_y  in  8  sprite top row, viewport-relative
- img_col  in  4  frame column index in sheet
- img_row  in  4  frame row index in sheet
- img_w  in  8  frame width in pixels
- img_h  in  7  frame height in pixels
- sheet_w  in  9  sheet row stride in pixels
- mirror  in  1  1 = flip horizontally
- busy  out  1  blit in progress
- done  out  1  one-cycle completion pulse
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  PIX_W  ROM data, valid ROM_LAT cycles after rom_rd
- fb_we  out  1  frame-buffer write enable
- fb_addr  out  FB_AW  frame-buffer address
- fb_data  out  PIX_W  frame-buffer write data

## Operation
- Reset: every output is 0; state is IDLE; the pipeline is cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on start; all inputs are latched at that edge.
  - RUN walks r = 0..img_h-1 (outer) and c = 0..img_w-1 (inner), one pixel per cycle. It moves to DRAIN after the last pixel.
  - DRAIN lasts ROM_LAT cycles, then moves to DONE.
  - DONE lasts one cycle with done = 1, then returns to IDLE.
  - If img_w = 0 or img_h = 0, start goes directly to DONE with no reads or writes.
- Source address: (img_row*img_h + r)*sheet_w + img_col*img_w + sc, truncated to ROM_AW.
  - sc = c when mirror = 0.
  - sc = img_w-1-c when mirror = 1.
- Destination: dx = pos_x - img_w/2 + c, dy = pos_y + r.
  - Both are computed as signed 11-bit values; img_w/2 is a floor division.
  - fb_addr = dy*VIEW_W + dx.
- Clipping: a pixel is in-bounds iff 0 <= dx < VIEW_W and 0 <= dy < VIEW_H.
  - For an out-of-bounds pixel, rom_rd is low that cycle and no write is ever issued; the walk still advances.
- Transparency: fb_we is asserted only when the pixel is in-bounds and rom_data != TRANSPARENT (0).
- start while busy is ignored and is not queued.
- Parameter changes during a blit have no effect, because all inputs are latched at start.
- Reset asserted mid-blit aborts immediately: fb_we drops asynchronously, no done is produced, and the block is in IDLE after release.

## Timing
- start is sampled high at edge 0.
- busy is 1 from cycle 1 through the DONE cycle inclusive.
- For N = img_w*img_h, pixel k (0-based) is presented on rom_addr/rom_rd in cycle 1+k.
- The matching fb_addr, fb_data and fb_we appear in cycle 1+k+ROM_LAT, aligned with rom_data.
- done pulses in cycle N+ROM_LAT+1.
- start is accepted again in cycle N+ROM_LAT+2, the first IDLE cycle.
- Throughput is 1 pixel/cycle with no stalls; the frame-buffer port must accept a write every cycle.

## Configuration
- BLIT_CLIP_EN defined: clipping is performed exactly as above.
- BLIT_CLIP_EN undefined:
  - No bounds checks; every pixel issues rom_rd.
  - Every non-transparent pixel is written.
  - fb_addr is dy*VIEW_W+dx truncated to FB_AW bits; the caller guarantees in-bounds placement.

## Structure
- Package kirby_gfx_pkg holds VIEW_W, VIEW_H, TRANSPARENT and the blit_state_t enum (IDLE, RUN, DRAIN, DONE).
- Sub-module blit_delay is a ROM_LAT-deep shift register carrying {valid, fb_addr}, aligned with rom_data.
- The top level contains the FSM, the r/c counters and the address arithmetic.

## Test plan
- Unmirrored, in-bounds, ROM_LAT = 2:
  - Stimulus: pos=(100,50), 4x2 frame, img_col=1, img_row=0, sheet_w=96; ROM holds a ramp 1..8.
  - Response: first rom_addr = 4; 8 writes to fb_addr 11798..11801 and 12032..12035; done in cycle 11.
- Mirror:
  - Stimulus: same as above with mirror = 1.
  - Response: rom_addr for row 0 runs 7,6,5,4; fb_addr sequence is unchanged.
- Transparency:
  - Stimulus: ROM returns 0 for every odd c.
  - Response: exactly 4 writes; done still occurs in cycle 11.
- Left clip:
  - Stimulus: pos_x = 1, img_w = 8, img_h = 1.
  - Response: 5 writes at dx = 0..4; rom_rd is low for c = 0..2; done occurs in cycle 11.
- Start while busy:
  - Stimulus: start pulsed again in cycle 3.
  - Response: ignored; exactly one done pulse.
- Reset mid-blit:
  - Stimulus: Reset_n low in cycle 4, released in cycle 6.
  - Response: busy, fb_we and done are 0 from the reset edge; a fresh start in cycle 8 completes normally.
- Zero size:
  - Stimulus: img_h = 0.
  - Response: done in cycle 1; no rom_rd or fb_we.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared graphics constants and the blitter state encoding.
package kirby_gfx_pkg;

   localparam int VIEW_W      = 234;
   localparam int VIEW_H      = 176;
   localparam int TRANSPARENT = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Request, sprite-ROM and frame-buffer signals of the sprite blitter.
// master = game logic / memories side, slave = blitter.
interface sprite_blitter_if #(
   parameter int ROM_AW = 18,
   parameter int FB_AW  = 16,
   parameter int PIX_W  = 4
);
   logic              start;
   logic [7:0]        pos_x;
   logic [7:0]        pos_y;
   logic [3:0]        img_col;
   logic [3:0]        img_row;
   logic [7:0]        img_w;
   logic [6:0]        img_h;
   logic [8:0]        sheet_w;
   logic              mirror;
   logic              busy;
   logic              done;
   logic              rom_rd;
   logic [ROM_AW-1:0] rom_addr;
   logic [PIX_W-1:0]  rom_data;
   logic              fb_we;
   logic [FB_AW-1:0]  fb_addr;
   logic [PIX_W-1:0]  fb_data;

   modport master (
      output start, pos_x, pos_y, img_col, img_row, img_w, img_h, sheet_w, mirror,
      output rom_data,
      input  busy, done, rom_rd, rom_addr, fb_we, fb_addr, fb_data
   );

   modport slave (
      input  start, pos_x, pos_y, img_col, img_row, img_w, img_h, sheet_w, mirror,
      input  rom_data,
      output busy, done, rom_rd, rom_addr, fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/sprite_blitter_delay.sv
// blit_delay: LAT-deep shift register carrying {valid, fb_addr} so the
// write address lines up with the ROM data returned LAT cycles later.
module blit_delay #(
   parameter int LAT = 2,
   parameter int AW  = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_vld,
   input  logic [AW-1:0] in_addr,
   output logic          out_vld,
   output logic [AW-1:0] out_addr
);
   logic [LAT-1:0]         vld_pipe;
   logic [LAT-1:0][AW-1:0] addr_pipe;

   // Shift valid/address one stage per clock; reset empties the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         vld_pipe[0]  <= in_vld;
         addr_pipe[0] <= in_addr;
         for (int i = 1; i < LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
      end
   end

   assign out_vld  = vld_pipe[LAT-1];
   assign out_addr = addr_pipe[LAT-1];
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one sprite frame from the sheet ROM into the
// viewport frame buffer, one pixel per clock, with mirroring and
// colour-key transparency.
// Build option: BLIT_CLIP_EN -- when defined, pixels outside the viewport
// are skipped (no ROM read, no write); otherwise all pixels are issued and
// fb_addr is simply truncated.
module sprite_blitter #(
   parameter int VIEW_W  = kirby_gfx_pkg::VIEW_W,
   parameter int VIEW_H  = kirby_gfx_pkg::VIEW_H,
   parameter int ROM_AW  = 18,
   parameter int FB_AW   = 16,
   parameter int PIX_W   = 4,
   parameter int ROM_LAT = 2
) (
   input  logic             Clk,
   input  logic             Reset_n,
   sprite_blitter_if.slave  bus
);
   import kirby_gfx_pkg::*;

   if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_chk
      $error("ROM_LAT must be 1..4");
   end
   if (VIEW_W * VIEW_H > (1 << FB_AW)) begin : g_fb_chk
      $error("viewport does not fit in frame-buffer address space");
   end

   blit_state_t state, nxt;

   // request latched at start
   logic [7:0] px, py, iw;
   logic [3:0] icol, irow;
   logic [6:0] ih;
   logic [8:0] sw;
   logic       mir;

   logic [6:0] r;
   logic [7:0] c;
   logic [2:0] dcnt;
   logic       last_pix;

   assign last_pix = (c == iw - 8'd1) && (r == ih - 7'd1);

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // Next-state: zero-size frames skip straight to DONE.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = (bus.img_w == 8'd0 || bus.img_h == 7'd0) ? DONE : RUN;
         RUN:     if (last_pix) nxt = DRAIN;
         DRAIN:   if (dcnt == 3'(ROM_LAT - 1)) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Latch the request and walk rows (outer) / columns (inner).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         px <= '0; py <= '0; iw <= '0; ih <= '0;
         icol <= '0; irow <= '0; sw <= '0; mir <= 1'b0;
         r <= '0; c <= '0; dcnt <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               px   <= bus.pos_x;   py   <= bus.pos_y;
               iw   <= bus.img_w;   ih   <= bus.img_h;
               icol <= bus.img_col; irow <= bus.img_row;
               sw   <= bus.sheet_w; mir  <= bus.mirror;
               r    <= '0;          c    <= '0;
               dcnt <= '0;
            end
            RUN: begin
               if (c == iw - 8'd1) begin
                  c <= '0;
                  r <= r + 7'd1;
               end else begin
                  c <= c + 8'd1;
               end
            end
            DRAIN:   dcnt <= dcnt + 3'd1;
            default: ;
         endcase
      end
   end

   // Source address in the sheet; mirroring only reverses the column.
   logic [7:0]  sc;
   logic [11:0] srow;
   logic [12:0] scol;
   logic [23:0] src;

   assign sc   = mir ? (iw - 8'd1 - c) : c;
   assign srow = 12'(irow) * 12'(ih) + 12'(r);
   assign scol = 13'(icol) * 13'(iw) + 13'(sc);
   assign src  = 24'(srow) * 24'(sw) + 24'(scol);

   // Destination, centred horizontally on pos_x; signed so left overhang is negative.
   logic signed [10:0] dx, dy;
   int                 fb_lin;
   logic               pix_ok;
   logic               rd;

   assign dx     = $signed({3'b0, px}) - $signed({4'b0, iw[7:1]}) + $signed({3'b0, c});
   assign dy     = $signed({3'b0, py}) + $signed({4'b0, r});
   assign fb_lin = int'(dy) * VIEW_W + int'(dx);

`ifdef BLIT_CLIP_EN
   assign pix_ok = (dx >= 0) && (int'(dx) < VIEW_W) && (dy >= 0) && (int'(dy) < VIEW_H);
`else
   assign pix_ok = 1'b1;
`endif

   assign rd = (state == RUN) && pix_ok;

   logic             d_vld;
   logic [FB_AW-1:0] d_addr;

   blit_delay #(.LAT(ROM_LAT), .AW(FB_AW)) u_delay (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .in_vld   (rd),
      .in_addr  (FB_AW'(fb_lin)),
      .out_vld  (d_vld),
      .out_addr (d_addr)
   );

   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
   assign bus.rom_rd   = rd;
   assign bus.rom_addr = (state == RUN) ? ROM_AW'(src) : '0;
   assign bus.fb_we    = d_vld && (bus.rom_data != PIX_W'(TRANSPARENT));
   assign bus.fb_addr  = d_addr;
   assign bus.fb_data  = d_vld ? bus.rom_data : '0;
endmodule
